decimal_key_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the ten decimal key lines that feed the decimal-to-binary encoder. It samples ten raw request lines and selects exactly one. It presents the winner as a one-hot grant vector and as its 4-bit binary code, then delivers that code downstream over a valid/ready handshake. It then waits for the winning key to be released before it arbitrates again.

---
 rtl/decimal_key_arbiter_if.sv | 31 +++
 rtl/decimal_key_arbiter.sv | 116 +++++++++++
 tb/tb_decimal_key_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/decimal_key_arbiter_if.sv
// Key-request and code-delivery bundle between the decimal key lines, the
// arbiter, and the downstream encoder consumer.
interface decimal_key_arbiter_if #(
  parameter int N      = 10,
  parameter int CODE_W = 4
);
  logic [N-1:0]      req;
  logic [N-1:0]      grant;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;
  logic              busy;

  modport master (
    input  req,
    input  ready,
    output grant,
    output code,
    output valid,
    output busy
  );

  modport slave (
    output req,
    output ready,
    input  grant,
    input  code,
    input  valid,
    input  busy
  );
endinterface

// File: rtl/decimal_key_arbiter.sv
// Round-robin arbiter for ten decimal key lines: latches one winner, delivers its
// code over valid/ready, then waits for that key to be released.
module decimal_key_arbiter #(
  parameter int N      = 10,
  parameter int CODE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  decimal_key_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] ptr_q,   ptr_d;
  logic [CODE_W-1:0] idx_q,   idx_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;

  logic [CODE_W-1:0] sel;
  logic              found;

  // Scan starting at ptr and wrapping 9->0; the first pressed key wins.
  always_comb begin : pick
    int                c;
    logic [CODE_W-1:0] c_idx;
    sel   = '0;
    found = 1'b0;
    c     = 0;
    c_idx = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      c_idx = CODE_W'(c);
      if (!found && bus.req[c_idx]) begin
        sel   = c_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    code_d  = code_q;
    grant_d = grant_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_PRESENT;
          idx_d   = sel;
          code_d  = sel;
          grant_d = N'(1) << sel;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_PRESENT: begin
        // The winner is latched, so a request dropped during a stall still delivers.
        if (valid_q && bus.ready) begin
          ptr_d   = (code_q == CODE_W'(N - 1)) ? '0 : code_q + 1'b1;
          state_d = S_RELEASE;
          code_d  = '0;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!bus.req[idx_q]) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = '0;
        grant_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_decimal_key_arbiter.sv
// Directed cycle-by-cycle vectors for the decimal key arbiter, followed by a
// random req/ready phase that checks the output invariants every cycle.
module tb_decimal_key_arbiter;

  localparam int N      = 10;
  localparam int CODE_W = 4;

  logic clk;
  logic reset;

  decimal_key_arbiter_if #(.N(N), .CODE_W(CODE_W)) bus ();

  decimal_key_arbiter #(.N(N), .CODE_W(CODE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [9:0]  req;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input string name, input logic rst, input logic [9:0] req,
                     input logic rdy, input logic ev, input logic [3:0] ec,
                     input logic eb);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.rdy = rdy;
    v.exp_valid = ev; v.exp_code = ec; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    logic [9:0] eg;
    eg = v.exp_valid ? (10'd1 << v.exp_code) : 10'd0;
    reset     = v.rst;
    bus.req   = v.req;
    bus.ready = v.rdy;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.valid !== v.exp_valid || bus.code !== v.exp_code ||
        bus.grant !== eg || bus.busy !== v.exp_busy) begin
      n_fail++;
      $display("FAIL %s: got valid=%b code=%0d grant=%b busy=%b, want valid=%b code=%0d grant=%b busy=%b",
               v.name, bus.valid, bus.code, bus.grant, bus.busy,
               v.exp_valid, v.exp_code, eg, v.exp_busy);
    end
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.req   = '0;
    bus.ready = 1'b0;

    // name, rst, req, rdy, exp_valid, exp_code, exp_busy
    add("reset",          1, 10'h000, 0, 0, 0, 0);
    add("single_grant",   0, 10'h020, 1, 1, 5, 1);
    add("single_xfer",    0, 10'h020, 1, 0, 0, 1);
    add("single_hold1",   0, 10'h020, 1, 0, 0, 1);
    add("single_hold2",   0, 10'h020, 1, 0, 0, 1);
    add("single_hold3",   0, 10'h020, 1, 0, 0, 1);
    add("single_rel",     0, 10'h000, 1, 0, 0, 0);
    add("single_idle",    0, 10'h000, 1, 0, 0, 0);
    add("rr_reset",       1, 10'h000, 0, 0, 0, 0);
    add("rr_win0",        0, 10'h205, 1, 1, 0, 1);
    add("rr_xfer0",       0, 10'h205, 1, 0, 0, 1);
    add("rr_rel0",        0, 10'h204, 1, 0, 0, 0);
    add("rr_win2",        0, 10'h205, 1, 1, 2, 1);
    add("rr_xfer2",       0, 10'h205, 1, 0, 0, 1);
    add("rr_rel2",        0, 10'h201, 1, 0, 0, 0);
    add("rr_win9",        0, 10'h205, 1, 1, 9, 1);
    add("rr_xfer9",       0, 10'h205, 1, 0, 0, 1);
    add("rr_rel9",        0, 10'h005, 1, 0, 0, 0);
    add("rr_wrap0",       0, 10'h205, 1, 1, 0, 1);
    add("rr_xfer0b",      0, 10'h205, 1, 0, 0, 1);
    add("rr_relall",      0, 10'h000, 1, 0, 0, 0);
    add("bp_grant7",      0, 10'h080, 0, 1, 7, 1);
    add("bp_stall1",      0, 10'h080, 0, 1, 7, 1);
    add("bp_stall2",      0, 10'h080, 0, 1, 7, 1);
    add("bp_drop1",       0, 10'h000, 0, 1, 7, 1);
    add("bp_drop2",       0, 10'h000, 0, 1, 7, 1);
    add("bp_drop3",       0, 10'h000, 0, 1, 7, 1);
    add("bp_xfer",        0, 10'h000, 1, 0, 0, 1);
    add("bp_rel",         0, 10'h000, 1, 0, 0, 0);
    add("hold_grant3",    0, 10'h008, 1, 1, 3, 1);
    add("hold_xfer3",     0, 10'h008, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) add("hold_key3",  0, 10'h008, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add("hold_ign4",  0, 10'h018, 1, 0, 0, 1);
    add("hold_rel3_idle", 0, 10'h010, 1, 0, 0, 0);
    add("hold_grant4",    0, 10'h010, 1, 1, 4, 1);
    add("hold_xfer4",     0, 10'h010, 1, 0, 0, 1);
    add("hold_rel4",      0, 10'h000, 1, 0, 0, 0);
    add("mid_grant8",     0, 10'h100, 0, 1, 8, 1);
    add("mid_stall8",     0, 10'h100, 0, 1, 8, 1);
    add("mid_reset",      1, 10'h100, 1, 0, 0, 0);
    add("mid_ptr_clear",  0, 10'h102, 0, 1, 1, 1);
    add("mid_xfer1",      0, 10'h102, 1, 0, 0, 1);
    add("mid_rel",        0, 10'h000, 1, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: a second press of the same key after full release delivers again.
    begin
      vec_t v;
      v.rst = 0; v.rdy = 1;
      v.name = "repress_grant5"; v.req = 10'h020; v.exp_valid = 1; v.exp_code = 5; v.exp_busy = 1; apply(v);
      v.name = "repress_xfer5";  v.req = 10'h020; v.exp_valid = 0; v.exp_code = 0; v.exp_busy = 1; apply(v);
      v.name = "repress_rel5";   v.req = 10'h000; v.exp_valid = 0; v.exp_code = 0; v.exp_busy = 0; apply(v);
      v.name = "repress_again5"; v.req = 10'h020; v.exp_valid = 1; v.exp_code = 5; v.exp_busy = 1; apply(v);
      v.name = "repress_xfer5b"; v.req = 10'h000; v.exp_valid = 0; v.exp_code = 0; v.exp_busy = 1; apply(v);
      v.name = "repress_done";   v.req = 10'h000; v.exp_valid = 0; v.exp_code = 0; v.exp_busy = 0; apply(v);
    end

    // Random req/ready: output invariants every cycle.
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset     = ($urandom_range(0, 99) == 0);
      bus.req   = 10'($urandom_range(0, 1023) & $urandom_range(0, 1023) & $urandom_range(0, 1023));
      bus.ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.code > 4'd9) begin
        n_fail++;
        $display("FAIL inv_code_range: got code=%0d, want <=9", bus.code);
      end
      n_tests++;
      if (bus.grant !== (bus.valid ? (10'd1 << bus.code) : 10'd0)) begin
        n_fail++;
        $display("FAIL inv_grant: got grant=%b with valid=%b code=%0d, want %b", bus.grant,
                 bus.valid, bus.code, bus.valid ? (10'd1 << bus.code) : 10'd0);
      end
      n_tests++;
      if ((bus.valid && !bus.busy) || (!bus.valid && bus.code != 4'd0)) begin
        n_fail++;
        $display("FAIL inv_valid_busy: got valid=%b busy=%b code=%0d, want busy when valid and code 0 when not",
                 bus.valid, bus.busy, bus.code);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
